quantize_sn: RTL and testbench

QUANTIZE_SN -- requirements
Module: quantize_sn

---
 rtl/quantize_sn.sv | 180 ++++++++++++++++++
 tb/tb_quantize_sn.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quantize_sn.sv
// Two-stage valid/ready quantizer: unsigned pixel -> zero-point subtract, rounded shift, signed clamp.
// Optional per-frame saturation counter enabled by defining QUANT_SAT_CNT_EN.
module quantize_sn #(
    parameter int                    IN_W       = 8,
    parameter int                    OUT_W      = 8,
    parameter logic signed [IN_W:0]  ZERO_POINT = 128,
    parameter int                    SHIFT      = 0,
    parameter int                    CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    srst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_pixel,
    input  logic                    in_line_last,
    input  logic                    in_frame_last,
    input  logic                    in_is_pad,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_W-1:0]        out_pixel,
    output logic                    out_line_last,
    output logic                    out_frame_last,
    output logic                    out_is_pad
`ifdef QUANT_SAT_CNT_EN
    ,
    output logic [CNT_W-1:0]        sat_count
`endif
);

    // Wide enough for d plus the rounding constant and for the clamp bounds.
    localparam int WW       = (IN_W + 3 > OUT_W + 1) ? IN_W + 3 : OUT_W + 1;
    localparam int SHIFT_M1 = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [WW-1:0] ZP_EXT  = WW'(ZERO_POINT);
    localparam logic signed [WW-1:0] RND     = WW'((SHIFT > 0) ? (1 << SHIFT_M1) : 0);
    localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        IDLE,
        IN_FRAME
    } frame_state_t;

    logic               s1_valid;
    logic [IN_W-1:0]    s1_pixel;
    logic               s1_line_last;
    logic               s1_frame_last;
    logic               s1_is_pad;

    logic               s2_valid;
    logic [OUT_W-1:0]   s2_pixel;
    logic               s2_line_last;
    logic               s2_frame_last;
    logic               s2_is_pad;

    logic               s2_load;
    logic               in_xfer;
    logic               out_xfer;

    logic signed [WW-1:0] diff;
    logic signed [WW-1:0] rounded;
    logic [OUT_W-1:0]     q_pixel;

`ifdef QUANT_SAT_CNT_EN
    logic               q_sat;
    logic               s2_sat;
    logic [CNT_W-1:0]   sat_acc;
    logic [CNT_W-1:0]   acc_next;
`endif

    frame_state_t       frame_state;

    assign s2_load  = !s2_valid || out_ready;
    assign in_ready = srst || !(s1_valid && s2_valid && !out_ready);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid && out_ready;

    assign out_valid      = s2_valid;
    assign out_pixel      = s2_pixel;
    assign out_line_last  = s2_line_last;
    assign out_frame_last = s2_frame_last;
    assign out_is_pad     = s2_is_pad;

    always_ff @(posedge clk) begin
        if (srst) begin
            s1_valid      <= 1'b0;
            s1_pixel      <= '0;
            s1_line_last  <= 1'b0;
            s1_frame_last <= 1'b0;
            s1_is_pad     <= 1'b0;
        end else if (in_xfer) begin
            s1_valid      <= 1'b1;
            s1_pixel      <= in_pixel;
            s1_line_last  <= in_line_last;
            s1_frame_last <= in_frame_last;
            s1_is_pad     <= in_is_pad;
        end else if (s2_load) begin
            s1_valid      <= 1'b0;
        end
    end

    always_comb begin
        diff    = $signed({{(WW-IN_W){1'b0}}, s1_pixel}) - ZP_EXT;
        rounded = (diff + RND) >>> SHIFT;
        q_pixel = rounded[OUT_W-1:0];
`ifdef QUANT_SAT_CNT_EN
        q_sat   = 1'b0;
`endif
        if (s1_is_pad) begin
            q_pixel = '0;
        end else if (rounded > SAT_MAX) begin
            q_pixel = SAT_MAX[OUT_W-1:0];
`ifdef QUANT_SAT_CNT_EN
            q_sat   = 1'b1;
`endif
        end else if (rounded < SAT_MIN) begin
            q_pixel = SAT_MIN[OUT_W-1:0];
`ifdef QUANT_SAT_CNT_EN
            q_sat   = 1'b1;
`endif
        end
    end

    // An empty S2 holds all-zero data so idle outputs read 0 without gating.
    always_ff @(posedge clk) begin
        if (srst) begin
            s2_valid      <= 1'b0;
            s2_pixel      <= '0;
            s2_line_last  <= 1'b0;
            s2_frame_last <= 1'b0;
            s2_is_pad     <= 1'b0;
        end else if (s2_load) begin
            s2_valid      <= s1_valid;
            s2_pixel      <= s1_valid ? q_pixel : '0;
            s2_line_last  <= s1_valid && s1_line_last;
            s2_frame_last <= s1_valid && s1_frame_last;
            s2_is_pad     <= s1_valid && s1_is_pad;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            frame_state <= IDLE;
        end else begin
            case (frame_state)
                IDLE:     if (out_xfer && !s2_frame_last) frame_state <= IN_FRAME;
                IN_FRAME: if (out_xfer && s2_frame_last)  frame_state <= IDLE;
                default:  frame_state <= IDLE;
            endcase
        end
    end

`ifdef QUANT_SAT_CNT_EN
    always_ff @(posedge clk) begin
        if (srst) begin
            s2_sat <= 1'b0;
        end else if (s2_load) begin
            s2_sat <= s1_valid && q_sat;
        end
    end

    assign acc_next = (s2_sat && !(&sat_acc)) ? sat_acc + CNT_W'(1) : sat_acc;

    // The frame's total is published together with its last beat, then restarts.
    always_ff @(posedge clk) begin
        if (srst) begin
            sat_acc   <= '0;
            sat_count <= '0;
        end else if (out_xfer) begin
            if (s2_frame_last) begin
                sat_count <= acc_next;
                sat_acc   <= '0;
            end else begin
                sat_acc   <= acc_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_quantize_sn.sv
// Bench for quantize_sn: three parameterizations share one stream, checked against an arithmetic model.
// Sat-count checks are active when QUANT_SAT_CNT_EN is defined.
module tb_quantize_sn;

    typedef struct {
        int pix;
        bit ll;
        bit fl;
        bit pad;
        int cyc;
    } beat_t;

    logic clk = 1'b0;
    logic srst;
    logic in_valid, in_line_last, in_frame_last, in_is_pad, out_ready;
    logic [7:0] in_pixel;

    logic in_ready_a, in_ready_b, in_ready_c;
    logic out_valid_a, out_valid_b, out_valid_c;
    logic [7:0] out_pixel_a, out_pixel_b;
    logic [3:0] out_pixel_c;
    logic out_line_last_a, out_frame_last_a, out_is_pad_a;
    logic out_line_last_b, out_frame_last_b, out_is_pad_b;
    logic out_line_last_c, out_frame_last_c, out_is_pad_c;
`ifdef QUANT_SAT_CNT_EN
    logic [15:0] sat_count_a, sat_count_b, sat_count_c;
`endif

    int cmp_count = 0;
    int err_count = 0;
    int cyc = 0;
    int n_accepted = 0;
    int acc = 0;
    int exp_sc = 0;
    bit lat_mode = 0;
    bit post_rst = 0;
    bit prev_stall = 0;
    int prev_pix = 0;
    logic [2:0] prev_side = '0;
    beat_t sb[$];

    always #5 clk = ~clk;

    quantize_sn #(.IN_W(8), .OUT_W(8), .ZERO_POINT(9'sd128), .SHIFT(0), .CNT_W(16)) dut_a (
        .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready_a), .in_pixel(in_pixel),
        .in_line_last(in_line_last), .in_frame_last(in_frame_last), .in_is_pad(in_is_pad),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_pixel(out_pixel_a),
        .out_line_last(out_line_last_a), .out_frame_last(out_frame_last_a), .out_is_pad(out_is_pad_a)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(sat_count_a)
`endif
    );

    quantize_sn #(.IN_W(8), .OUT_W(8), .ZERO_POINT(9'sd128), .SHIFT(1), .CNT_W(16)) dut_b (
        .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready_b), .in_pixel(in_pixel),
        .in_line_last(in_line_last), .in_frame_last(in_frame_last), .in_is_pad(in_is_pad),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_pixel(out_pixel_b),
        .out_line_last(out_line_last_b), .out_frame_last(out_frame_last_b), .out_is_pad(out_is_pad_b)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(sat_count_b)
`endif
    );

    quantize_sn #(.IN_W(8), .OUT_W(4), .ZERO_POINT(9'sd0), .SHIFT(0), .CNT_W(16)) dut_c (
        .clk(clk), .srst(srst), .in_valid(in_valid), .in_ready(in_ready_c), .in_pixel(in_pixel),
        .in_line_last(in_line_last), .in_frame_last(in_frame_last), .in_is_pad(in_is_pad),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_pixel(out_pixel_c),
        .out_line_last(out_line_last_c), .out_frame_last(out_frame_last_c), .out_is_pad(out_is_pad_c)
`ifdef QUANT_SAT_CNT_EN
        , .sat_count(sat_count_c)
`endif
    );

    function automatic int floor_div(input int n, input int m);
        if (n >= 0) return n / m;
        return -((-n + m - 1) / m);
    endfunction

    // Reference quantizer: plain integer arithmetic on the mathematical definition.
    function automatic int quant(input int pix, input int zp, input int sh, input int ow,
                                 input bit pad, output bit sat);
        int d, r, hi, lo;
        sat = 1'b0;
        if (pad) return 0;
        d  = pix - zp;
        r  = (sh > 0) ? floor_div(d + (1 << (sh - 1)), 1 << sh) : d;
        hi = (1 << (ow - 1)) - 1;
        lo = -(1 << (ow - 1));
        if (r > hi) begin r = hi; sat = 1'b1; end
        else if (r < lo) begin r = lo; sat = 1'b1; end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                               input logic signed [31:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycleMonitor();
        beat_t b;
        bit sa, sbt, sc;
        int ea, eb, ec;
        cyc++;
        if (srst) begin
            checkOutput("ready_in_reset", {31'd0, in_ready_a}, 1);
            sb.delete();
            prev_stall = 0;
            acc = 0;
            exp_sc = 0;
            return;
        end
        if (post_rst) begin
            checkOutput("rst_valid", {31'd0, out_valid_a}, 0);
            checkOutput("rst_pixel", $signed(out_pixel_a), 0);
            checkOutput("rst_ready", {31'd0, in_ready_a}, 1);
            post_rst = 0;
        end
        checkOutput("in_ready", {31'd0, in_ready_a}, (sb.size() == 2 && !out_ready) ? 0 : 1);
`ifdef QUANT_SAT_CNT_EN
        checkOutput("sat_count", {16'd0, sat_count_c}, exp_sc);
`endif
        if (prev_stall) begin
            checkOutput("stall_valid", {31'd0, out_valid_a}, 1);
            checkOutput("stall_pixel", $signed(out_pixel_a), prev_pix);
            checkOutput("stall_side", {29'd0, out_line_last_a, out_frame_last_a, out_is_pad_a},
                        {29'd0, prev_side});
        end
        if (out_valid_a) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_valid", {31'd0, out_valid_a}, 0);
            end else begin
                b  = sb[0];
                ea = quant(b.pix, 128, 0, 8, b.pad, sa);
                eb = quant(b.pix, 128, 1, 8, b.pad, sbt);
                ec = quant(b.pix, 0, 0, 4, b.pad, sc);
                checkOutput("pixel_a", $signed(out_pixel_a), ea);
                checkOutput("pixel_b", $signed(out_pixel_b), eb);
                checkOutput("pixel_c", $signed(out_pixel_c), ec);
                checkOutput("side", {29'd0, out_line_last_a, out_frame_last_a, out_is_pad_a},
                            {29'd0, b.ll, b.fl, b.pad});
                if (lat_mode) checkOutput("latency", cyc - b.cyc, 2);
                if (out_ready) begin
                    void'(sb.pop_front());
                    if (sc && acc < 65535) acc++;
                    if (b.fl) begin
                        exp_sc = acc;
                        acc = 0;
                    end
                end
            end
        end else begin
            checkOutput("idle_side", {29'd0, out_line_last_a, out_frame_last_a, out_is_pad_a}, 0);
        end
        prev_stall = out_valid_a && !out_ready;
        prev_pix   = $signed(out_pixel_a);
        prev_side  = {out_line_last_a, out_frame_last_a, out_is_pad_a};
        if (in_valid && in_ready_a) begin
            sb.push_back('{pix: int'(in_pixel), ll: in_line_last, fl: in_frame_last,
                           pad: in_is_pad, cyc: cyc});
            n_accepted++;
        end
    endtask

    task automatic applyStimulus(input bit v, input int pix, input bit ll, input bit fl,
                                 input bit pad, input bit ordy);
        in_valid      = v;
        in_pixel      = 8'(pix);
        in_line_last  = ll;
        in_frame_last = fl;
        in_is_pad     = pad;
        out_ready     = ordy;
        @(negedge clk);
        cycleMonitor();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb.size() > 0; i++) applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("drain_empty", sb.size(), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        int start;
        srst = 1'b1;
        applyStimulus(1, 77, 1, 1, 0, 1);
        applyStimulus(1, 78, 0, 0, 0, 1);
        srst = 1'b0;
        post_rst = 1;
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Full-throughput directed beats: basic values, shift cases, pad, and sat frames.
        lat_mode = 1;
        applyStimulus(1, 200, 0, 0, 0, 1);
        applyStimulus(1, 0,   0, 0, 0, 1);
        applyStimulus(1, 255, 0, 0, 0, 1);
        applyStimulus(1, 129, 1, 1, 0, 1);
        applyStimulus(1, 200, 0, 0, 0, 1);
        applyStimulus(1, 3,   0, 0, 0, 1);
        applyStimulus(1, 200, 0, 0, 1, 1);
        applyStimulus(1, 50,  1, 1, 0, 1);
        applyStimulus(1, 3,   0, 0, 0, 1);
        applyStimulus(1, 5,   1, 1, 0, 1);
        drain();
        applyStimulus(0, 0, 0, 0, 0, 1);

        // out_ready alternating 0101 with input held valid.
        lat_mode = 0;
        start = n_accepted;
        for (int i = 0; i < 200 && n_accepted - start < 10; i++)
            applyStimulus(1, $urandom_range(0, 255), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) == 0), 1'(i % 2));
        checkOutput("alt_beats", n_accepted - start, 10);
        drain();

        start = n_accepted;
        for (int i = 0; i < 400 && n_accepted - start < 40; i++)
            applyStimulus(1'($urandom), $urandom_range(0, 255), 1'($urandom), 1'($urandom),
                          1'($urandom_range(0, 3) == 0), 1'($urandom));
        checkOutput("rand_beats", n_accepted - start, 40);
        drain();

        // Reset with two beats in flight, then one fresh beat.
        applyStimulus(1, 20, 0, 0, 0, 0);
        applyStimulus(1, 21, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);
        srst = 1'b1;
        applyStimulus(1, 99, 0, 1, 0, 1);
        srst = 1'b0;
        post_rst = 1;
        lat_mode = 1;
        applyStimulus(1, 10, 1, 1, 0, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
